// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  localparam int PC_W  = 32;
  localparam int IMM_W = 16;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0040_0000;
  localparam logic [PC_W-1:0] NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_target_calc.sv
// Branch target: PC+4 of the branch plus the sign-extended word offset.
module fetch_target_calc
  import fetch_pkg::*;
(
  input  logic [PC_W-1:0]  i_pc4,
  input  logic [IMM_W-1:0] i_imm16,
  output logic [PC_W-1:0]  o_target
);

  logic signed [PC_W-1:0] w_offset;

  assign w_offset = {{(PC_W-IMM_W-2){i_imm16[IMM_W-1]}}, i_imm16, 2'b00};
  assign o_target = i_pc4 + $unsigned(w_offset);

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC and IF/ID register, fetches over a req/ack
// instruction-memory handshake, honours stalls and EX branch redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [PC_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IFstall,
  input  logic             nPC_sel,
  input  logic [IMM_W-1:0] br_imm16,
  input  logic [PC_W-1:0]  br_pc4,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [PC_W-1:0]  imem_rdata,
  output logic [PC_W-1:0]  IDInst,
  output logic [PC_W-1:0]  IDpc4,
  output logic             IDvalid,
  output logic             drop_pulse
);

  fetch_state_e    r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_req;
  logic [PC_W-1:0] r_skid;
  logic [PC_W-1:0] r_idinst;
  logic [PC_W-1:0] r_idpc4;
  logic            r_idvalid;
  logic            r_drop;

  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc4;
  logic            w_ack;

  fetch_target_calc u_target (
    .i_pc4    (br_pc4),
    .i_imm16  (br_imm16),
    .o_target (w_target)
  );

  assign w_pc4 = pc_inc(r_pc);
  assign w_ack = r_req & imem_ack;

  assign imem_req   = r_req;
  assign imem_addr  = r_pc;
  assign IDInst     = r_idinst;
  assign IDpc4      = r_idpc4;
  assign IDvalid    = r_idvalid;
  assign drop_pulse = r_drop;

  // Pipeline registers advance on the falling edge, like the other stages.
  always_ff @(negedge clk) begin
    r_drop <= 1'b0;
    if (reset) begin
      r_state   <= FETCH;
      r_pc      <= RESET_PC;
      r_req     <= 1'b0;
      r_idinst  <= NOP_INST;
      r_idpc4   <= '0;
      r_idvalid <= 1'b0;
    end else if (nPC_sel) begin
      r_pc      <= w_target;
      r_idinst  <= NOP_INST;
      r_idvalid <= 1'b0;
      r_req     <= 1'b1;
      // A request still in flight answers the old address, so it must be drained.
      if (w_ack) begin
        r_drop  <= 1'b1;
        r_state <= FETCH;
      end else if (r_req && r_state != HOLD) begin
        r_state <= DROP;
      end else begin
        r_state <= FETCH;
      end
    end else begin
      unique case (r_state)
        FETCH: begin
          if (!r_req) begin
            r_req <= 1'b1;
          end else if (w_ack && !IFstall) begin
            r_idinst  <= imem_rdata;
            r_idpc4   <= w_pc4;
            r_idvalid <= 1'b1;
            r_pc      <= w_pc4;
          end else if (w_ack) begin
            r_skid  <= imem_rdata;
            r_req   <= 1'b0;
            r_state <= HOLD;
          end else if (!IFstall) begin
            r_idinst  <= NOP_INST;
            r_idvalid <= 1'b0;
          end
        end
        HOLD: begin
          if (!IFstall) begin
            r_idinst  <= r_skid;
            r_idpc4   <= w_pc4;
            r_idvalid <= 1'b1;
            r_pc      <= w_pc4;
            r_req     <= 1'b1;
            r_state   <= FETCH;
          end
        end
        DROP: begin
          if (!IFstall) begin
            r_idinst  <= NOP_INST;
            r_idvalid <= 1'b0;
          end
          if (w_ack) begin
            r_drop  <= 1'b1;
            r_state <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency instruction memory.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b1;
  logic        reset = 1'b1;
  logic        IFstall = 1'b0;
  logic        nPC_sel = 1'b0;
  logic [15:0] br_imm16 = '0;
  logic [31:0] br_pc4 = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IDInst;
  logic [31:0] IDpc4;
  logic        IDvalid;
  logic        drop_pulse;

  logic [31:0] t_pc4;
  logic [15:0] t_imm;
  logic [31:0] t_target;

  int n_checks = 0;
  int n_fail   = 0;

  int          lat = 0;
  logic        m_busy = 1'b0;
  logic [31:0] m_addr = '0;
  int          m_cnt = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .IFstall    (IFstall),
    .nPC_sel    (nPC_sel),
    .br_imm16   (br_imm16),
    .br_pc4     (br_pc4),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .IDInst     (IDInst),
    .IDpc4      (IDpc4),
    .IDvalid    (IDvalid),
    .drop_pulse (drop_pulse)
  );

  fetch_target_calc u_tc (
    .i_pc4    (t_pc4),
    .i_imm16  (t_imm),
    .o_target (t_target)
  );

  // Memory returns the address it latched at request start, after lat wait cycles.
  assign imem_ack   = imem_req && (m_cnt == lat);
  assign imem_rdata = m_busy ? m_addr : imem_addr;

  always @(negedge clk) begin
    if (reset || !imem_req || imem_ack) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_busy <= 1'b1;
      m_cnt  <= m_cnt + 1;
      if (!m_busy) m_addr <= imem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic [31:0] tv_pc4 [5] = '{32'h0040_0010, 32'h0040_0020, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFFC};
  logic [15:0] tv_imm [5] = '{16'hFFFC, 16'h0004, 16'h0003, 16'h8000, 16'h0001};
  logic [31:0] tv_exp [5] = '{32'h0040_0000, 32'h0040_0030, 32'hFFFF_FFFC, 32'hFFFE_0000, 32'h0000_0000};

  initial begin
    bit seen;

    for (int i = 0; i < 5; i++) begin
      t_pc4 = tv_pc4[i];
      t_imm = tv_imm[i];
      #1;
      chk($sformatf("target%0d", i), t_target, tv_exp[i]);
    end

    tick();
    tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0040_0000);
    chk("rst_inst", IDInst, 32'h0);
    chk("rst_pc4", IDpc4, 32'h0);
    chk("rst_valid", {31'b0, IDvalid}, 32'd0);
    chk("rst_drop", {31'b0, drop_pulse}, 32'd0);

    reset = 1'b0;
    tick();
    chk("e1_req", {31'b0, imem_req}, 32'd1);
    chk("e1_valid", {31'b0, IDvalid}, 32'd0);
    tick();
    chk("e2_inst", IDInst, 32'h0040_0000);
    chk("e2_valid", {31'b0, IDvalid}, 32'd1);
    chk("e2_pc4", IDpc4, 32'h0040_0004);
    tick();
    chk("e3_inst", IDInst, 32'h0040_0004);
    chk("e3_addr", imem_addr, 32'h0040_0008);

    IFstall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold%0d_req", i), {31'b0, imem_req}, 32'd0);
      chk($sformatf("hold%0d_inst", i), IDInst, 32'h0040_0004);
    end
    IFstall = 1'b0;
    tick();
    chk("rel_inst", IDInst, 32'h0040_0008);
    chk("rel_addr", imem_addr, 32'h0040_000C);
    chk("rel_req", {31'b0, imem_req}, 32'd1);

    nPC_sel = 1'b1; br_pc4 = 32'h0040_0010; br_imm16 = 16'hFFFC;
    tick();
    chk("br_addr", imem_addr, 32'h0040_0000);
    chk("br_valid", {31'b0, IDvalid}, 32'd0);
    chk("br_inst", IDInst, 32'h0);
    chk("br_drop", {31'b0, drop_pulse}, 32'd1);
    nPC_sel = 1'b0;
    tick();
    chk("br_next_inst", IDInst, 32'h0040_0000);
    chk("br_next_valid", {31'b0, IDvalid}, 32'd1);
    chk("br_next_drop", {31'b0, drop_pulse}, 32'd0);

    nPC_sel = 1'b1; br_pc4 = 32'hFFFF_FFF0; br_imm16 = 16'h0003;
    tick();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    nPC_sel = 1'b0;
    tick();
    chk("wrap_inst", IDInst, 32'hFFFF_FFFC);
    chk("wrap_pc4", IDpc4, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);

    IFstall = 1'b1;
    tick();
    chk("hr_req", {31'b0, imem_req}, 32'd0);
    reset = 1'b1;
    tick();
    chk("hr_addr", imem_addr, 32'h0040_0000);
    chk("hr_valid", {31'b0, IDvalid}, 32'd0);
    chk("hr_req0", {31'b0, imem_req}, 32'd0);
    chk("hr_inst", IDInst, 32'h0);
    reset = 1'b0; IFstall = 1'b0;
    tick();
    chk("hr_fetch_req", {31'b0, imem_req}, 32'd1);
    chk("hr_fetch_valid", {31'b0, IDvalid}, 32'd0);
    tick();
    chk("hr_first_inst", IDInst, 32'h0040_0000);

    reset = 1'b1; lat = 2;
    tick();
    reset = 1'b0;
    tick();
    chk("lat_req", {31'b0, imem_req}, 32'd1);
    chk("lat_addr0", imem_addr, 32'h0040_0000);
    nPC_sel = 1'b1; br_pc4 = 32'h0040_0020; br_imm16 = 16'h0004;
    tick();
    chk("lat_br_addr", imem_addr, 32'h0040_0030);
    chk("lat_br_drop", {31'b0, drop_pulse}, 32'd0);
    chk("lat_br_valid", {31'b0, IDvalid}, 32'd0);
    nPC_sel = 1'b0;
    tick();
    chk("lat_wait_drop", {31'b0, drop_pulse}, 32'd0);
    chk("lat_wait_addr", imem_addr, 32'h0040_0030);
    tick();
    chk("lat_drop", {31'b0, drop_pulse}, 32'd1);
    chk("lat_drop_valid", {31'b0, IDvalid}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (IDvalid) seen = 1'b1;
    end
    chk("lat_timeout", {31'b0, seen}, 32'd1);
    chk("lat_inst", IDInst, 32'h0040_0030);
    chk("lat_pc4", IDpc4, 32'h0040_0034);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
